// File: rtl/fazyrv_pc_ctrl.sv
// Serial next-PC sequencer: shifts a 32-bit next PC through the PC register chunk by chunk.
// Optional misalign detection is enabled by defining FAZYRV_PC_CTRL_MISALIGN_EN.
//   state | meaning
//   FLUSH | clear stale PC carry after reset (D cycles)
//   IDLE  | ready, waiting for start_i
//   SHIFT | N chunk shifts, LSB first
//   DRAIN | absorb top-chunk carry (D cycles), done_o on the last one
module fazyrv_pc_ctrl #(
  parameter int unsigned CHUNKSIZE = 2,
  parameter logic [31:0] TRAPVEC   = 32'h0000_0010,
  localparam int unsigned N        = 32 / CHUNKSIZE,
  localparam int unsigned IDXW     = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 start_i,
  input  logic [1:0]           src_i,
  input  logic [CHUNKSIZE-1:0] tgt_i,
  input  logic [CHUNKSIZE-1:0] pc_ser_i,
  input  logic [CHUNKSIZE-1:0] pc_ser_inc_i,
  output logic                 pc_inc_o,
  output logic                 pc_shift_o,
  output logic [CHUNKSIZE-1:0] pc_din_o,
  output logic [CHUNKSIZE-1:0] link_o,
  output logic                 link_vld_o,
  output logic [IDXW-1:0]      chunk_idx_o,
  output logic                 rdy_o,
  output logic                 done_o,
  output logic                 misalign_o
);

  localparam int unsigned D = (CHUNKSIZE == 1) ? 2 : 1;
`ifdef FAZYRV_PC_CTRL_MISALIGN_EN
  localparam int FORCE_BITS = 2;
`else
  localparam int FORCE_BITS = 1;
`endif

  localparam logic [1:0] SRC_INC  = 2'd0;
  localparam logic [1:0] SRC_TGT  = 2'd1;
  localparam logic [1:0] SRC_TRAP = 2'd2;

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_SHIFT, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      tmr_q;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      src_q;
  logic [31:0]     trap_q;
  logic            tmr_zero;
  logic            last_chunk;
  logic            shifting;
  logic [CHUNKSIZE-1:0] din;

  assign tmr_zero   = (tmr_q == 2'd0);
  assign last_chunk = (idx_q == IDXW'(N - 1));
  assign shifting   = (state_q == S_SHIFT);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state_q <= S_FLUSH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FLUSH: if (tmr_zero)   state_d = S_IDLE;
      S_IDLE:  if (start_i)    state_d = S_SHIFT;
      S_SHIFT: if (last_chunk) state_d = S_DRAIN;
      S_DRAIN: if (tmr_zero)   state_d = S_IDLE;
      default:                 state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      tmr_q  <= 2'(D - 1);
      idx_q  <= '0;
      src_q  <= SRC_INC;
      trap_q <= '0;
    end else begin
      case (state_q)
        S_FLUSH, S_DRAIN: begin
          if (!tmr_zero) tmr_q <= tmr_q - 2'd1;
        end
        S_IDLE: begin
          if (start_i) begin
            src_q  <= src_i;
            idx_q  <= '0;
            trap_q <= TRAPVEC;
          end
        end
        S_SHIFT: begin
          idx_q  <= last_chunk ? '0 : idx_q + IDXW'(1);
          trap_q <= trap_q >> CHUNKSIZE;
          if (last_chunk) tmr_q <= 2'(D - 1);
        end
        default: ;
      endcase
    end
  end

  // Target chunks lose their absolute low address bits so the PC stays aligned.
  always_comb begin
    din = '0;
    case (src_q)
      SRC_INC:  din = pc_ser_inc_i;
      SRC_TGT: begin
        din = tgt_i;
        for (int j = 0; j < int'(CHUNKSIZE); j++)
          if (int'(idx_q) * int'(CHUNKSIZE) + j < FORCE_BITS) din[j] = 1'b0;
      end
      SRC_TRAP: din = trap_q[CHUNKSIZE-1:0];
      default:  din = pc_ser_i;
    endcase
  end

`ifdef FAZYRV_PC_CTRL_MISALIGN_EN
  logic mis_q;
  logic mis_hit;

  always_comb begin
    mis_hit = 1'b0;
    if (shifting && src_q == SRC_TGT)
      for (int j = 0; j < int'(CHUNKSIZE); j++)
        if (int'(idx_q) * int'(CHUNKSIZE) + j == 1 && tgt_i[j]) mis_hit = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in)                          mis_q <= 1'b0;
    else if (state_q == S_IDLE && start_i) mis_q <= 1'b0;
    else if (mis_hit)                     mis_q <= 1'b1;
  end

  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_shift_o  = shifting;
  assign pc_inc_o    = shifting && (idx_q == '0);
  assign pc_din_o    = shifting ? din : '0;
  assign link_o      = shifting ? pc_ser_inc_i : '0;
  assign link_vld_o  = shifting;
  assign chunk_idx_o = idx_q;
  assign rdy_o       = (state_q == S_IDLE);
  assign done_o      = (state_q == S_DRAIN) && tmr_zero;

endmodule

// File: tb/tb_fazyrv_pc_ctrl.sv
// Scoreboard bench for fazyrv_pc_ctrl: a word-level PC stub feeds the DUT, a reference model
// predicts each operation's new PC, link value, misalign flag and done cycle.
module tb_fazyrv_pc_ctrl;
  localparam int CS   = 2;
  localparam int N    = 32 / CS;
  localparam int D    = (CS == 1) ? 2 : 1;
  localparam int IDXW = $clog2(N);
  localparam logic [31:0] TRAPVEC = 32'h0000_0010;
`ifdef FAZYRV_PC_CTRL_MISALIGN_EN
  localparam logic [31:0] TGT_MASK = ~32'h3;
  localparam bit MIS_EN = 1'b1;
`else
  localparam logic [31:0] TGT_MASK = ~32'h1;
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] src = 2'd0;
  logic [CS-1:0] tgt, pc_ser, pc_ser_inc, pc_din, link;
  logic pc_inc, pc_shift, link_vld, rdy, done, misalign;
  logic [IDXW-1:0] chunk_idx;

  fazyrv_pc_ctrl #(.CHUNKSIZE(CS), .TRAPVEC(TRAPVEC)) dut (
    .clk_i(clk), .rst_in(rst_n), .start_i(start), .src_i(src), .tgt_i(tgt),
    .pc_ser_i(pc_ser), .pc_ser_inc_i(pc_ser_inc), .pc_inc_o(pc_inc),
    .pc_shift_o(pc_shift), .pc_din_o(pc_din), .link_o(link), .link_vld_o(link_vld),
    .chunk_idx_o(chunk_idx), .rdy_o(rdy), .done_o(done), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PC register stub, word level: presents chunk shift_cnt of pc_cur and pc_cur+4.
  logic [31:0] pc_cur = 32'h0, pc_nxt = 32'h0, link_acc = 32'h0, tgt_val = 32'h0;
  logic [31:0] pc_plus4;
  int shift_cnt = 0;
  assign pc_plus4   = pc_cur + 32'd4;
  assign pc_ser     = pc_cur[shift_cnt*CS +: CS];
  assign pc_ser_inc = pc_plus4[shift_cnt*CS +: CS];
  assign tgt        = tgt_val[shift_cnt*CS +: CS];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] lnk;
    logic        mis;
    int          t;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_pc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pc_shift) begin
        check("inc_strobe", 32'(pc_inc), 32'(shift_cnt == 0));
        check("link_vld", 32'(link_vld), 32'd1);
        check("chunk_idx", 32'(chunk_idx), 32'(shift_cnt));
        pc_nxt[shift_cnt*CS +: CS]   = pc_din;
        link_acc[shift_cnt*CS +: CS] = link;
        shift_cnt++;
        if (shift_cnt == N) begin
          pc_cur    = pc_nxt;
          shift_cnt = 0;
        end
      end else begin
        check("idle_strobes", 32'({pc_inc, link_vld}), 32'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("new_pc", pc_cur, e.pc);
          check("link", link_acc, e.lnk);
          check("misalign", 32'(misalign), 32'(e.mis));
          check("done_cycle", 32'(cyc), 32'(e.t + N + D));
        end
      end
    end
  end

  task automatic do_op(input logic [1:0] s, input logic [31:0] tv, input bit spur,
                       input bit ld, input logic [31:0] ldv);
    int guard;
    exp_t e;
    guard = 0;
    @(posedge clk); #1;
    while (!rdy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!rdy) begin
      n_vec++; n_err++;
      $display("FAIL rdy_timeout: got rdy=0 expected rdy=1 within 200 cycles");
      return;
    end
    if (ld) begin
      pc_cur   = ldv;
      model_pc = ldv;
    end
    case (s)
      2'd0:    e.pc = model_pc + 32'd4;
      2'd1:    e.pc = tv & TGT_MASK;
      2'd2:    e.pc = TRAPVEC;
      default: e.pc = model_pc;
    endcase
    e.lnk    = model_pc + 32'd4;
    e.mis    = MIS_EN && s == 2'd1 && tv[1];
    e.t      = cyc;
    q.push_back(e);
    model_pc = e.pc;
    tgt_val  = tv;
    src      = s;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src   = 2'($urandom_range(0, 3));
    if (spur) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      src   = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic release_and_check_flush();
    int r;
    @(posedge clk); #1;
    rst_n = 1'b1;
    r = cyc;
    for (int i = 0; i <= D; i++) begin
      @(negedge clk);
      check("flush_rdy", 32'(rdy), 32'(cyc >= r + D));
    end
  endtask

  task automatic wait_drained();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending ops expected 0", q.size());
    end
  endtask

  initial begin
    int guard;
    #1;
    check("reset_outputs", 32'({pc_inc, pc_shift, pc_din, link, link_vld, chunk_idx, rdy, done, misalign}), 32'd0);
    repeat (2) @(posedge clk);
    release_and_check_flush();

    do_op(2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    do_op(2'd0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    do_op(2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_op(2'd1, 32'h8000_0006, 1'b0, 1'b0, 32'h0);
    do_op(2'd1, 32'h8000_0008, 1'b0, 1'b0, 32'h0);
    do_op(2'd2, $urandom, 1'b1, 1'b0, 32'h0);
    do_op(2'd3, $urandom, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 40; i++)
      do_op(2'($urandom_range(0, 3)), $urandom, bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), $urandom);
    wait_drained();

    // Async reset in the middle of a shift.
    do_op(2'd0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    guard = 0;
    @(negedge clk);
    while (!(pc_shift && chunk_idx == IDXW'(5)) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_chunk5", 32'(chunk_idx), 32'd5);
    rst_n = 1'b0;
    #1;
    check("midshift_reset_outputs", 32'({pc_inc, pc_shift, pc_din, link, link_vld, chunk_idx, rdy, done, misalign}), 32'd0);
    q.delete();
    shift_cnt = 0;
    pc_cur    = 32'h0;
    model_pc  = 32'h0;
    repeat (2) @(posedge clk);
    release_and_check_flush();
    do_op(2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_op(2'd1, 32'h0000_4000, 1'b0, 1'b0, 32'h0);
    wait_drained();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
